// File: rtl/mmio_bridge.sv
// mmio_bridge: CPU-to-peripheral MMIO bridge with an address-window check and an error counter.
// Define MMIO_BRIDGE_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES without mmio_ready.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h1000_0000
`endif
`ifndef IO_LED_OFFSET
`define IO_LED_OFFSET 32'h0000_0000
`endif

module mmio_bridge #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int WINDOW_BYTES   = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [`ADDR_W-1:0] cpu_addr,
  input  logic [`XLEN-1:0]   cpu_wdata,
  output logic [`XLEN-1:0]   cpu_rdata,
  output logic               cpu_ready,
  output logic               cpu_err,
  output logic               mmio_req,
  output logic               mmio_we,
  output logic [`ADDR_W-1:0] mmio_addr,
  output logic [`XLEN-1:0]   mmio_wdata,
  input  logic [`XLEN-1:0]   mmio_rdata,
  input  logic               mmio_ready,
  output logic [7:0]         err_count
);
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mmio_bridge: TIMEOUT_CYCLES out of range 2..65535");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [`ADDR_W-1:0] addr_q, addr_d;
  logic [`XLEN-1:0]   wdata_q, wdata_d;
  logic [`XLEN-1:0]   rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic [`ADDR_W-1:0] offs;
  logic               legal;
  logic               busy;
  logic               done;
  logic               timeout;
  // Subtract first so the window test cannot overflow near the top of the address space.
  assign offs  = cpu_addr - `IO_BASE_ADDR;
  assign legal = (cpu_addr[1:0] == 2'b00) && (cpu_addr >= `IO_BASE_ADDR) &&
                 (offs < `ADDR_W'(WINDOW_BYTES));
`ifdef MMIO_BRIDGE_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign timeout = cnt_q == 16'(TIMEOUT_CYCLES);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: if (cpu_req) begin
        if (legal) begin
          state_d = BUSY;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
          cnt_d   = 16'd1;
`endif
        end else begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      BUSY: if (mmio_ready) begin
        state_d = DONE;
        err_d   = 1'b0;
        rdata_d = we_q ? '0 : mmio_rdata;
      end else if (timeout) begin
        state_d = DONE;
        err_d   = 1'b1;
        rdata_d = '0;
      end else begin
`ifdef MMIO_BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q + 16'd1;
`endif
      end
      DONE: begin
        state_d   = IDLE;
        err_cnt_d = (err_q && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end
  // Outputs are gated by state so every bus reads zero outside its active phase.
  assign busy       = state_q == BUSY;
  assign done       = state_q == DONE;
  assign mmio_req   = busy;
  assign mmio_we    = busy & we_q;
  assign mmio_addr  = busy ? addr_q : '0;
  assign mmio_wdata = busy ? wdata_q : '0;
  assign cpu_ready  = done;
  assign cpu_err    = done & err_q;
  assign cpu_rdata  = done ? rdata_q : '0;
  assign err_count  = err_cnt_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: randomized scoreboard bench for mmio_bridge with a register-file peripheral stub.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h1000_0000
`endif
`ifndef IO_LED_OFFSET
`define IO_LED_OFFSET 32'h0000_0000
`endif

module tb_mmio_bridge;
  localparam int TO  = 64;
  localparam int WIN = 256;
  localparam logic [31:0] BASE = `IO_BASE_ADDR;
  localparam logic [31:0] LED  = `IO_BASE_ADDR + `IO_LED_OFFSET;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        mmio_req;
  logic        mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata = '0;
  logic        mmio_ready = 1'b0;
  logic [7:0]  err_count;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [31:0] regs[WIN/4];
  logic [31:0] ref_mem[WIN/4];
  int          exp_cnt = 0;
  int          delay_sel = -1;
  bit          stall = 1'b0;
  int          wait_cnt = 0;
  bit          prev_hs = 1'b0;

  mmio_bridge #(.TIMEOUT_CYCLES(TO), .WINDOW_BYTES(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'(o[7:2]);
  endfunction

  function automatic bit is_legal(input logic [31:0] a);
    return a[1:0] == 2'b00 && a >= BASE && (a - BASE) < WIN;
  endfunction

  // Peripheral stub: answers after a programmable delay, toggles noise on mmio_ready while idle.
  always @(posedge clk) begin
    #1;
    if (mmio_req && !stall) begin
      if (wait_cnt <= 0) begin
        mmio_ready = 1'b1;
        mmio_rdata = mmio_we ? $urandom : regs[widx(mmio_addr)];
        if (mmio_we) regs[widx(mmio_addr)] = mmio_wdata;
      end else begin
        mmio_ready = 1'b0;
        wait_cnt--;
      end
    end else begin
      mmio_ready = mmio_req ? 1'b0 : 1'($urandom_range(0, 1));
      mmio_rdata = $urandom;
      wait_cnt   = delay_sel < 0 ? int'($urandom_range(0, 3)) : delay_sel;
    end
  end

  // Monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prev_hs = 1'b0;
    else begin
      if (prev_hs) chk("ready_after_mmio_ready", 32'(cpu_ready), 32'd1);
      prev_hs = mmio_req && mmio_ready;
      if (cpu_ready) begin
        if (exp_q.size() == 0) chk("unexpected_cpu_ready", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("cpu_rdata", cpu_rdata, e.rdata);
          chk("cpu_err", 32'(cpu_err), 32'(e.err));
          chk("mmio_req_in_done", 32'(mmio_req), 32'd0);
        end
      end else begin
        chk("idle_rdata_zero", cpu_rdata, 32'd0);
        chk("idle_err_zero", 32'(cpu_err), 32'd0);
      end
    end
  end

  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd, input bit drop);
    exp_t e;
    bit   lg;
    int   n;
    lg = is_legal(addr);
    if (!lg) e = '{32'd0, 1'b1};
    else if (we) begin
      ref_mem[widx(addr)] = wd;
      e = '{32'd0, 1'b0};
    end else e = '{ref_mem[widx(addr)], 1'b0};
    exp_q.push_back(e);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk); #1;
    chk("mmio_req_after_accept", 32'(mmio_req), 32'(lg));
    if (!lg) chk("err_latency", 32'(cpu_ready), 32'd1);
    if (drop) cpu_req = 1'b0;
    n = 0;
    while (!cpu_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cpu_ready) chk("cpu_ready_wait_expired", 32'd0, 32'd1);
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    if (e.err && exp_cnt < 255) exp_cnt++;
    @(posedge clk); #1;
    chk("err_count", 32'(err_count), 32'(exp_cnt));
  endtask

  function automatic logic [31:0] rand_addr();
    int s;
    s = $urandom_range(0, 5);
    if (s <= 2) return BASE + 32'($urandom_range(0, WIN / 4 - 1)) * 4;
    if (s == 3) return BASE + 32'($urandom_range(0, WIN - 1)) | 32'($urandom_range(1, 3));
    if (s == 4) return BASE + WIN + 32'($urandom_range(0, 255)) * 4;
    return BASE - 32'($urandom_range(1, 64)) * 4;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < WIN / 4; i++) begin
      regs[i] = '0;
      ref_mem[i] = '0;
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = LED; cpu_wdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mmio_req", 32'(mmio_req), 32'd0);
    chk("rst_mmio_we", 32'(mmio_we), 32'd0);
    chk("rst_mmio_addr", mmio_addr, 32'd0);
    chk("rst_mmio_wdata", mmio_wdata, 32'd0);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_cpu_err", 32'(cpu_err), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    cpu_req = 1'b0;
    rst_n = 1'b1;
    delay_sel = 1;
    do_txn(1'b1, LED, 32'h0000_A5A5, 1'b0);
    chk("led_out", 32'(regs[widx(LED)][15:0]), 32'h0000_A5A5);
    do_txn(1'b0, LED, 32'h0, 1'b0);
    do_txn(1'b0, BASE + 32'h100, 32'h0, 1'b0);
    do_txn(1'b0, BASE + 32'h2, 32'h0, 1'b0);
    chk("err_count_two", 32'(err_count), 32'd2);
    delay_sel = -1;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
    stall = 1'b1;
    exp_q.push_back('{32'd0, 1'b1});
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = LED;
    n = 0;
    for (int c = 0; c < 1000 && !cpu_ready; c++) begin
      @(posedge clk); #1;
      if (mmio_req) n++;
    end
    chk("timeout_req_cycles", 32'(n), 32'(TO));
    chk("timeout_ready", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b0;
    if (exp_cnt < 255) exp_cnt++;
    @(posedge clk); #1;
    chk("timeout_err_count", 32'(err_count), 32'(exp_cnt));
    stall = 1'b0;
`endif
    stall = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = LED;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_reset", 32'(mmio_req), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_drops_mmio_req", 32'(mmio_req), 32'd0);
    chk("reset_no_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1; cpu_req = 1'b0; stall = 1'b0;
    exp_cnt = 0;
    do_txn(1'b1, LED, 32'h0000_5A5A, 1'b0);
    chk("led_after_reset", 32'(regs[widx(LED)][15:0]), 32'h0000_5A5A);
    for (int i = 0; i < 300; i++)
      do_txn(1'($urandom), rand_addr(), $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 260; i++)
      do_txn(1'($urandom), BASE + WIN + 32'(i) * 4, $urandom, 1'b0);
    chk("err_count_saturated", 32'(err_count), 32'd255);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
